regfile_wb_ctrl: RTL and testbench

Write-back controller for the 32-entry register file: initialises the file after reset, arbitrates two write-back requesters onto the single write port, and keeps a pending-write scoreboard so issue logic can tell whether the registers selected on the two read ports hold stale data. It sits between the pipeline write-back stages and the register file's write port (`en`/`sd`/`D`), and drives that port directly.

---
 rtl/regfile_ctrl_pkg.sv | 21 ++
 rtl/rr_arb2.sv | 38 +++
 rtl/regfile_wb_ctrl.sv | 127 ++++++++++++
 tb/tb_regfile_wb_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_ctrl_pkg.sv
// ============================================================================
// Module   : regfile_ctrl_pkg
// Brief    : Shared types and sizes for the register-file write-back controller
// Revision : 1.0
// ============================================================================
`default_nettype none

package regfile_ctrl_pkg;

  localparam int NREG  = 32;
  localparam int AW    = 5;
  localparam int DEF_N = 32;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// Module   : rr_arb2
// Brief    : Two-requester round-robin arbiter with registered last-grant pointer
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_arb2 (
  input  logic clock,
  input  logic R,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  // 1 means requester 1 was granted last, so requester 0 wins the next tie
  logic r_last;

  always_comb begin
    gnt0 = en && req0 && (!req1 || r_last);
    gnt1 = en && req1 && !gnt0;
  end

  always_ff @(posedge clock or negedge R) begin
    if (!R) begin
      r_last <= 1'b1;
    end else if (gnt0) begin
      r_last <= 1'b0;
    end else if (gnt1) begin
      r_last <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_wb_ctrl.sv
// ============================================================================
// Module   : regfile_wb_ctrl
// Brief    : Register-file init, write-back arbitration and pending-write scoreboard
// Revision : 1.0
// ============================================================================
`default_nettype none

module regfile_wb_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic          clock,
  input  logic          R,
  input  logic          clr_req,
  output logic          init_done,
  input  logic          w0_valid,
  output logic          w0_ready,
  input  logic [AW-1:0] w0_addr,
  input  logic [N-1:0]  w0_data,
  input  logic          w1_valid,
  output logic          w1_ready,
  input  logic [AW-1:0] w1_addr,
  input  logic [N-1:0]  w1_data,
  input  logic          rsv_valid,
  output logic          rsv_ready,
  input  logic [AW-1:0] rsv_addr,
  input  logic [AW-1:0] rd_a_sel,
  input  logic [AW-1:0] rd_b_sel,
  output logic          rd_a_busy,
  output logic          rd_b_busy,
  output logic          rf_en,
  output logic [AW-1:0] rf_sd,
  output logic [N-1:0]  rf_D
);

  state_t          r_state, w_state_d;
  logic [AW-1:0]   r_cnt, w_cnt_d;
  logic [NREG-1:0] r_pend, w_pend_d;
  logic            w_run, w_clr, w_gnt0, w_gnt1, w_acc, w_rsv_acc;
  logic [AW-1:0]   w_addr;
  logic [N-1:0]    w_data;

  assign w_run = (r_state == RUN);
  assign w_clr = w_run && clr_req;

  rr_arb2 u_arb (
    .clock (clock),
    .R     (R),
    .en    (w_run && !clr_req),
    .req0  (w0_valid),
    .req1  (w1_valid),
    .gnt0  (w_gnt0),
    .gnt1  (w_gnt1)
  );

  assign w0_ready  = w_gnt0;
  assign w1_ready  = w_gnt1;
  assign w_acc     = w_gnt0 || w_gnt1;
  assign w_addr    = w_gnt1 ? w1_addr : w0_addr;
  assign w_data    = w_gnt1 ? w1_data : w0_data;
  assign init_done = w_run;
  assign rsv_ready = w_run && !r_pend[rsv_addr];
  assign w_rsv_acc = rsv_valid && rsv_ready;
  assign rd_a_busy = r_pend[rd_a_sel];
  assign rd_b_busy = r_pend[rd_b_sel];

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    case (r_state)
      CLEAR: begin
        w_cnt_d = r_cnt + 1'b1;
        if (r_cnt == AW'(NREG - 1)) w_state_d = RUN;
      end
      RUN: begin
        if (clr_req) begin
          w_state_d = CLEAR;
          w_cnt_d   = '0;
        end
      end
      default: w_state_d = CLEAR;
    endcase
  end

  // Commit clears first so a same-edge reservation of that register wins
  always_comb begin
    w_pend_d = r_pend;
    if (rf_en) w_pend_d[rf_sd] = 1'b0;
    if (w_rsv_acc && !(ZERO_REG && (rsv_addr == '0))) w_pend_d[rsv_addr] = 1'b1;
    if (w_clr) w_pend_d = '0;
  end

  always_ff @(posedge clock or negedge R) begin
    if (!R) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
      r_pend  <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_pend  <= w_pend_d;
    end
  end

  always_ff @(posedge clock or negedge R) begin
    if (!R) begin
      rf_en <= 1'b0;
      rf_sd <= '0;
      rf_D  <= '0;
    end else if (r_state == CLEAR) begin
      rf_en <= 1'b1;
      rf_sd <= r_cnt;
      rf_D  <= '0;
    end else if (w_acc) begin
      rf_en <= !(ZERO_REG && (w_addr == '0));
      rf_sd <= w_addr;
      rf_D  <= w_data;
    end else begin
      rf_en <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_ctrl.sv
// ============================================================================
// Module   : tb_regfile_wb_ctrl
// Brief    : Scoreboard bench for regfile_wb_ctrl (ZERO_REG=1 instance)
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_regfile_wb_ctrl;

  localparam int N = 32;

  logic          clock = 1'b0;
  logic          R = 1'b0;
  logic          clr_req = 1'b0;
  logic          init_done;
  logic          w0_valid = 1'b0, w1_valid = 1'b0, rsv_valid = 1'b0;
  logic          w0_ready, w1_ready, rsv_ready;
  logic [4:0]    w0_addr = '0, w1_addr = '0, rsv_addr = '0;
  logic [N-1:0]  w0_data = '0, w1_data = '0;
  logic [4:0]    rd_a_sel = '0, rd_b_sel = '0;
  logic          rd_a_busy, rd_b_busy;
  logic          rf_en;
  logic [4:0]    rf_sd;
  logic [N-1:0]  rf_D;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [4:0]   sd;
    logic [N-1:0] d;
  } wr_t;

  wr_t exp_q[$];

  regfile_wb_ctrl #(.N(N), .ZERO_REG(1'b1)) dut (
    .clock     (clock),
    .R         (R),
    .clr_req   (clr_req),
    .init_done (init_done),
    .w0_valid  (w0_valid),
    .w0_ready  (w0_ready),
    .w0_addr   (w0_addr),
    .w0_data   (w0_data),
    .w1_valid  (w1_valid),
    .w1_ready  (w1_ready),
    .w1_addr   (w1_addr),
    .w1_data   (w1_data),
    .rsv_valid (rsv_valid),
    .rsv_ready (rsv_ready),
    .rsv_addr  (rsv_addr),
    .rd_a_sel  (rd_a_sel),
    .rd_b_sel  (rd_b_sel),
    .rd_a_busy (rd_a_busy),
    .rd_b_busy (rd_b_busy),
    .rf_en     (rf_en),
    .rf_sd     (rf_sd),
    .rf_D      (rf_D)
  );

  always #5 clock = ~clock;

  task automatic chk1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_clears();
    for (int i = 0; i < 32; i++) exp_q.push_back(wr_t'{5'(i), 32'h0});
  endtask

  // Write-port monitor: every cycle with rf_en high must match the next expected write
  initial begin : monitor
    wr_t e;
    forever begin
      @(negedge clock);
      if (R && rf_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got sd=%0d D=%0h expected none at %0t", rf_sd, rf_D, $time);
        end else begin
          e = exp_q.pop_front();
          chk32("wr_addr", 32'(rf_sd), 32'(e.sd));
          chk32("wr_data", rf_D, e.d);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n0, n1;

    // ---------------- reset and initial clear ----------------
    push_clears();
    repeat (2) @(posedge clock);
    #2;
    chk1("rst_rf_en", rf_en, 1'b0);
    chk32("rst_rf_sd", 32'(rf_sd), 32'h0);
    chk32("rst_rf_D", rf_D, 32'h0);
    chk1("rst_init_done", init_done, 1'b0);
    R = 1'b1;
    w0_valid = 1'b1; w0_addr = 5'd1;
    w1_valid = 1'b1; w1_addr = 5'd2;
    rsv_valid = 1'b1; rsv_addr = 5'd3;
    for (int i = 0; i < 32; i++) begin
      @(posedge clock); #2;
      chk1("clr_rf_en", rf_en, 1'b1);
      chk1("clr_init_done", init_done, i == 31);
      if (i < 31) begin
        chk1("clr_w0_ready", w0_ready, 1'b0);
        chk1("clr_w1_ready", w1_ready, 1'b0);
        chk1("clr_rsv_ready", rsv_ready, 1'b0);
      end
      if (i == 30) begin
        w0_valid = 1'b0; w1_valid = 1'b0; rsv_valid = 1'b0;
      end
    end
    repeat (8) @(posedge clock);
    #2;
    chk1("idle_rf_en", rf_en, 1'b0);
    chk1("idle_init_done", init_done, 1'b1);

    // ---------------- reserve r5, write r5 ----------------
    @(posedge clock); #1;
    rsv_valid = 1'b1; rsv_addr = 5'd5; rd_a_sel = 5'd5;
    #1;
    chk1("r5_rsv_ready", rsv_ready, 1'b1);
    chk1("r5_busy_before", rd_a_busy, 1'b0);
    @(posedge clock); #1;
    rsv_valid = 1'b0;
    w0_valid = 1'b1; w0_addr = 5'd5; w0_data = 32'hDEADBEEF;
    #1;
    chk1("r5_busy_rsv", rd_a_busy, 1'b1);
    chk1("r5_w0_ready", w0_ready, 1'b1);
    exp_q.push_back(wr_t'{5'd5, 32'hDEADBEEF});
    @(posedge clock); #1;
    w0_valid = 1'b0;
    #1;
    chk1("r5_busy_k1", rd_a_busy, 1'b1);
    chk1("r5_rf_en_k1", rf_en, 1'b1);
    @(posedge clock); #2;
    chk1("r5_busy_k2", rd_a_busy, 1'b0);
    chk1("r5_rf_en_k2", rf_en, 1'b0);
    chk32("r5_hold_sd", 32'(rf_sd), 32'd5);
    chk32("r5_hold_D", rf_D, 32'hDEADBEEF);

    // ---------------- solo w1 so requester 0 wins the next tie ----------------
    @(posedge clock); #1;
    w1_valid = 1'b1; w1_addr = 5'd3; w1_data = 32'h33;
    #1;
    chk1("solo_w1_ready", w1_ready, 1'b1);
    chk1("solo_w0_ready", w0_ready, 1'b0);
    exp_q.push_back(wr_t'{5'd3, 32'h33});
    @(posedge clock); #1;
    w1_valid = 1'b0;

    // ---------------- continuous contention ----------------
    n0 = 0; n1 = 0;
    w0_valid = 1'b1; w0_addr = 5'd1;
    w1_valid = 1'b1; w1_addr = 5'd2;
    for (int i = 0; i < 6; i++) begin
      w0_data = 32'hA000_0000 + 32'(n0);
      w1_data = 32'hB000_0000 + 32'(n1);
      #1;
      if (i % 2 == 0) begin
        chk1("cont_w0_ready", w0_ready, 1'b1);
        chk1("cont_w1_ready", w1_ready, 1'b0);
        exp_q.push_back(wr_t'{5'd1, 32'hA000_0000 + 32'(n0)});
        n0++;
      end else begin
        chk1("cont_w0_ready", w0_ready, 1'b0);
        chk1("cont_w1_ready", w1_ready, 1'b1);
        exp_q.push_back(wr_t'{5'd2, 32'hB000_0000 + 32'(n1)});
        n1++;
      end
      if (i > 0) chk1("cont_rf_en", rf_en, 1'b1);
      @(posedge clock); #1;
    end
    w0_valid = 1'b0; w1_valid = 1'b0;
    #1;
    chk1("cont_rf_en_last", rf_en, 1'b1);

    // ---------------- r7 pending blocks reservation ----------------
    @(posedge clock); #1;
    rsv_valid = 1'b1; rsv_addr = 5'd7; rd_b_sel = 5'd7;
    #1;
    chk1("r7_first_rsv", rsv_ready, 1'b1);
    @(posedge clock); #1; #1;
    chk1("r7_rsv_blocked0", rsv_ready, 1'b0);
    chk1("r7_busy", rd_b_busy, 1'b1);
    @(posedge clock); #1;
    w1_valid = 1'b1; w1_addr = 5'd7; w1_data = 32'h77;
    #1;
    chk1("r7_w1_ready", w1_ready, 1'b1);
    chk1("r7_rsv_blocked1", rsv_ready, 1'b0);
    exp_q.push_back(wr_t'{5'd7, 32'h77});
    @(posedge clock); #1;
    w1_valid = 1'b0;
    #1;
    chk1("r7_rsv_blocked_k1", rsv_ready, 1'b0);
    @(posedge clock); #2;
    chk1("r7_rsv_ready_k2", rsv_ready, 1'b1);
    @(posedge clock); #1;
    rsv_valid = 1'b0;
    #1;
    chk1("r7_busy_again", rd_b_busy, 1'b1);

    // ---------------- read-only r0 ----------------
    @(posedge clock); #1;
    rsv_valid = 1'b1; rsv_addr = 5'd0; rd_a_sel = 5'd0;
    w0_valid = 1'b1; w0_addr = 5'd0; w0_data = 32'h1234;
    #1;
    chk1("r0_rsv_ready", rsv_ready, 1'b1);
    chk1("r0_w0_ready", w0_ready, 1'b1);
    @(posedge clock); #1;
    rsv_valid = 1'b0; w0_valid = 1'b0;
    #1;
    chk1("r0_rf_en", rf_en, 1'b0);
    chk1("r0_busy_k1", rd_a_busy, 1'b0);
    @(posedge clock); #2;
    chk1("r0_busy_k2", rd_a_busy, 1'b0);
    chk1("r0_rf_en_k2", rf_en, 1'b0);

    // ---------------- clr_req behind an r9 write ----------------
    rd_a_sel = 5'd7; rd_b_sel = 5'd9;
    @(posedge clock); #1;
    rsv_valid = 1'b1; rsv_addr = 5'd9;
    #1;
    chk1("r9_rsv_ready", rsv_ready, 1'b1);
    @(posedge clock); #1;
    rsv_valid = 1'b0;
    w0_valid = 1'b1; w0_addr = 5'd9; w0_data = 32'h99;
    #1;
    chk1("r9_w0_ready", w0_ready, 1'b1);
    chk1("r9_busy", rd_b_busy, 1'b1);
    exp_q.push_back(wr_t'{5'd9, 32'h99});
    push_clears();
    @(posedge clock); #1;
    w0_valid = 1'b0;
    clr_req = 1'b1;
    w1_valid = 1'b1; w1_addr = 5'd4; w1_data = 32'h44;
    #1;
    chk1("clrreq_w1_ready", w1_ready, 1'b0);
    chk1("clrreq_rf_en", rf_en, 1'b1);
    chk1("clrreq_init_done", init_done, 1'b1);
    @(posedge clock); #1;
    clr_req = 1'b0; w1_valid = 1'b0;
    #1;
    chk1("reclr_init_done", init_done, 1'b0);
    chk1("reclr_busy_a", rd_a_busy, 1'b0);
    chk1("reclr_busy_b", rd_b_busy, 1'b0);
    chk1("reclr_rf_en_gap", rf_en, 1'b0);
    for (int i = 0; i < 32; i++) begin
      @(posedge clock); #2;
      chk1("reclr_rf_en", rf_en, 1'b1);
      chk1("reclr_init_done_run", init_done, i == 31);
    end
    repeat (3) @(posedge clock);
    #2;
    chk1("end_rf_en", rf_en, 1'b0);
    chk32("end_queue_empty", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
